// File: rtl/challengeqsys_imem_pkg.sv
// Shared widths and master ids for the imem port-2 arbiter.
// Imported by the arbiter top and its grant sub-module.
package challengeqsys_imem_pkg;

  localparam int IMEM_ADDR_W = 11;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_BE_W   = 4;

  typedef logic [0:0] imem_mid_t;

  localparam imem_mid_t MID_LOADER = 1'b0;
  localparam imem_mid_t MID_DEBUG  = 1'b1;

  // One-hot grant vector to the winning master id.
  function automatic imem_mid_t grant_to_mid(input logic [1:0] g);
    return g[1] ? MID_DEBUG : MID_LOADER;
  endfunction

endpackage

// File: rtl/challengeqsys_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins,
// on a tie the master that did not win last time wins.
module challengeqsys_rr_arb2
  import challengeqsys_imem_pkg::*;
(
  input  logic [1:0] req,
  input  imem_mid_t  last_grant,
  output logic [1:0] grant
);

  // Pick at most one winner from the request pair.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == MID_LOADER)
                       ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/challengeqsys_imem_port_arbiter.sv
// Shares imem port 2 between the loader (m0) and the
// debug reader (m1); read data returns one cycle after grant.
module challengeqsys_imem_port_arbiter
  import challengeqsys_imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int BE_W   = IMEM_BE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  imem_mid_t  r_last_grant;
  logic       r_rd_pending;
  imem_mid_t  r_rd_owner;

  logic [1:0] w_req;
  logic [1:0] w_grant;
  imem_mid_t  w_win;
  logic       w_rd_grant;

  // Nothing is granted while reset is held.
  assign w_req = {m1_read | m1_write,
                  m0_read | m0_write} & {2{~reset}};

  challengeqsys_rr_arb2 u_arb (
    .req        (w_req),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  assign w_win = grant_to_mid(w_grant);

  assign m0_waitrequest = ~w_grant[0];
  assign m1_waitrequest = ~w_grant[1];

  // Read+write together counts as a write: no return.
  assign w_rd_grant =
      (w_grant[0] & m0_read & ~m0_write)
    | (w_grant[1] & m1_read & ~m1_write);

  // Route the winner's command; idle defaults to m0 fields.
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_chipselect = |w_grant;
    mem_write      = 1'b0;
    if (w_grant[1]) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end else if (w_grant[0]) begin
      mem_write      = m0_write;
    end
  end

  // Round-robin history and the read-return tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= MID_DEBUG;
      r_rd_pending <= 1'b0;
      r_rd_owner   <= MID_LOADER;
    end else begin
      if (|w_grant) begin
        r_last_grant <= w_win;
      end
      r_rd_pending <= w_rd_grant;
      if (w_rd_grant) begin
        r_rd_owner <= w_win;
      end
    end
  end

  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;

  // A return in flight when reset arrives is dropped.
  assign m0_readdatavalid = r_rd_pending & ~reset
                          & (r_rd_owner == MID_LOADER);
  assign m1_readdatavalid = r_rd_pending & ~reset
                          & (r_rd_owner == MID_DEBUG);

endmodule

// File: tb/tb_challengeqsys_imem_port_arbiter.sv
// Bench for the imem port arbiter: RAM model, behavioural
// reference with per-cycle compare, directed and random stimulus.
module tb_challengeqsys_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0;
  logic        m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [10:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  challengeqsys_imem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // RAM contents (driven by DUT) and shadow (driven by model)
  logic [31:0] ram [2048];
  logic [31:0] shd [2048];

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 'h100) return 32'h11223344;
    return (i * 32'h01000193) ^ 32'h5A5A0000;
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i] = init_word(i);
      shd[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b])
            ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model state
  bit          m_last = 1'b1;
  bit          m_pend = 1'b0;
  bit          m_own = 1'b0;
  logic [31:0] m_pdata = '0;
  bit          gf0 = 1'b0, gf1 = 1'b0;

  always @(negedge clk) begin
    bit r0, r1, g0, g1, ev0, ev1, w, wr;
    logic [10:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    ev0 = !reset && m_pend && !m_own;
    ev1 = !reset && m_pend && m_own;
    chk("rdv0", 32'(m0_readdatavalid), 32'(ev0));
    chk("rdv1", 32'(m1_readdatavalid), 32'(ev1));
    if (ev0) chk("rdata0", m0_readdata, m_pdata);
    if (ev1) chk("rdata1", m1_readdata, m_pdata);
    r0 = !reset && (m0_read || m0_write);
    r1 = !reset && (m1_read || m1_write);
    g0 = r0 && (!r1 || m_last);
    g1 = r1 && (!r0 || !m_last);
    w  = g1;
    a  = w ? m1_address : m0_address;
    be = w ? m1_byteenable : m0_byteenable;
    wd = w ? m1_writedata : m0_writedata;
    wr = w ? m1_write : m0_write;
    chk("wait0", 32'(m0_waitrequest), 32'(!g0));
    chk("wait1", 32'(m1_waitrequest), 32'(!g1));
    chk("cs", 32'(mem_chipselect), 32'(g0 || g1));
    chk("mwr", 32'(mem_write), 32'((g0 || g1) && wr));
    if (g0 || g1) begin
      chk("maddr", 32'(mem_address), 32'(a));
      if (wr) begin
        chk("mbe", 32'(mem_byteenable), 32'(be));
        chk("mwd", mem_writedata, wd);
      end
    end
    m_pend = 1'b0;
    if (reset) begin
      m_last = 1'b1;
    end else if (g0 || g1) begin
      m_last = w;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) shd[a][8*b +: 8] = wd[8*b +: 8];
      end else begin
        m_pend = 1'b1;
        m_own = w;
        m_pdata = shd[a];
      end
    end
    gf0 = g0;
    gf1 = g1;
  end

  task automatic setm(input int m, input bit rd,
                      input bit wr, input logic [10:0] a,
                      input logic [3:0] be,
                      input logic [31:0] wd);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a;
      m0_byteenable = be; m0_writedata = wd;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a;
      m1_byteenable = be; m1_writedata = wd;
    end
  endtask

  task automatic idle();
    setm(0, 0, 0, '0, '0, '0);
    setm(1, 0, 0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit busy;
    repeat (2) step();
    @(negedge clk);
    chk("rst_wait0", 32'(m0_waitrequest), 32'd1);
    chk("rst_wait1", 32'(m1_waitrequest), 32'd1);
    chk("rst_cs", 32'(mem_chipselect), 32'd0);
    chk("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
    step();
    reset = 1'b0;

    setm(0, 1, 0, 11'h005, 4'hF, '0);
    @(negedge clk);
    chk("t1_wait0", 32'(m0_waitrequest), 32'd0);
    step(); idle();
    @(negedge clk);
    chk("t1_rdv0", 32'(m0_readdatavalid), 32'd1);
    chk("t1_data", m0_readdata, 32'hDEADBEEF);
    chk("t1_rdv1", 32'(m1_readdatavalid), 32'd0);
    step();

    for (int k = 0; k < 6; k++) begin
      setm(0, 1, 0, 11'h010, 4'hF, '0);
      setm(1, 1, 0, 11'h020, 4'hF, '0);
      @(negedge clk);
      chk("t2_alt", 32'(m0_waitrequest), 32'(k % 2 == 0));
      step();
    end
    idle();
    step();

    setm(0, 0, 1, 11'h100, 4'b0011, 32'hA5A5A5A5);
    step();
    idle();
    setm(1, 1, 0, 11'h100, 4'hF, '0);
    step(); idle();
    @(negedge clk);
    chk("t3_rdv1", 32'(m1_readdatavalid), 32'd1);
    chk("t3_data", m1_readdata, 32'h1122A5A5);
    step();

    setm(0, 1, 1, 11'h7FF, 4'hF, 32'h12345678);
    @(negedge clk);
    chk("t4_mwr", 32'(mem_write), 32'd1);
    step(); idle();
    @(negedge clk);
    chk("t4_nordv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
    step();
    setm(0, 1, 0, 11'h7FF, 4'hF, '0);
    step(); idle();
    @(negedge clk);
    chk("t4_data", m0_readdata, 32'h12345678);
    step();

    setm(1, 1, 0, 11'h020, 4'hF, '0);
    step();
    idle(); reset = 1'b1;
    setm(0, 1, 0, 11'h005, 4'hF, '0);
    @(negedge clk);
    chk("t5_rdv1", 32'(m1_readdatavalid), 32'd0);
    chk("t5_cs", 32'(mem_chipselect), 32'd0);
    step();
    reset = 1'b0;
    setm(1, 1, 0, 11'h020, 4'hF, '0);
    @(negedge clk);
    chk("t5_tie0", 32'(m0_waitrequest), 32'd0);
    chk("t5_tie1", 32'(m1_waitrequest), 32'd1);
    step(); idle(); step();

    setm(0, 1, 0, 11'h005, 4'hF, '0);
    step();
    idle(); reset = 1'b1;
    step();
    reset = 1'b0;
    setm(0, 1, 0, 11'h005, 4'hF, '0);
    setm(1, 1, 0, 11'h006, 4'hF, '0);
    @(negedge clk);
    chk("t5b_tie0", 32'(m0_waitrequest), 32'd0);
    step(); idle(); step();

    for (int k = 0; k < 3; k++) begin
      setm(1, 1, 0, 11'(k), 4'hF, '0);
      @(negedge clk);
      chk("t6_solo1", 32'(m1_waitrequest), 32'd0);
      step();
    end
    setm(0, 1, 0, 11'h003, 4'hF, '0);
    setm(1, 1, 0, 11'h004, 4'hF, '0);
    @(negedge clk);
    chk("t6_join0", 32'(m0_waitrequest), 32'd0);
    chk("t6_join1", 32'(m1_waitrequest), 32'd1);
    step();
    @(negedge clk);
    chk("t6_next1", 32'(m1_waitrequest), 32'd0);
    step(); idle(); step();

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int m = 0; m < 2; m++) begin
        busy = (m == 0) ? (m0_read || m0_write)
                        : (m1_read || m1_write);
        if (!busy || ((m == 0) ? gf0 : gf1)) begin
          if ($urandom_range(0, 9) < 7) begin
            int op;
            logic [10:0] a;
            op = $urandom_range(0, 5);
            a = ($urandom_range(0, 7) == 0)
                ? 11'(11'h7F8 + $urandom_range(0, 7))
                : 11'($urandom_range(0, 7));
            setm(m, op != 1 && op != 2, op >= 1 && op <= 3,
                 a, 4'($urandom_range(0, 15)), $urandom);
          end else begin
            setm(m, 0, 0, '0, '0, '0);
          end
        end
      end
      step();
    end
    reset = 1'b0;
    idle();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
